// File: rtl/mult_booth_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : mult_booth_pipe_if
// Description : Operand/result handshake bundle for mult_booth_pipe.
//               slave = multiplier side, master = producer/consumer side.
// Revision    : 1.0 - initial release
// ============================================================================
interface mult_booth_pipe_if #(
    parameter int WIDTH = 16,
    parameter int GUARD = 8
);
    localparam int ACC_W = 2 * WIDTH + GUARD;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_a_signed;
    logic             in_b_signed;
    logic             in_acc;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_p;

    modport slave (
        input  in_valid, in_a, in_b, in_a_signed, in_b_signed, in_acc, out_ready,
        output in_ready, out_valid, out_p
    );

    modport master (
        output in_valid, in_a, in_b, in_a_signed, in_b_signed, in_acc, out_ready,
        input  in_ready, out_valid, out_p
    );
endinterface
`default_nettype wire

// File: rtl/mult_booth_pipe.sv
`default_nettype none
// ============================================================================
// Module      : mult_booth_pipe
// Description : 3-stage radix-4 Booth multiplier-accumulator.
//               S1 Booth partial products, S2 3:2 carry-save reduction,
//               S3 carry-propagate add + accumulator. valid/ready handshake
//               with full-pipeline stall on output backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_booth_pipe #(
    parameter int WIDTH = 16,
    parameter int GUARD = 8
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    mult_booth_pipe_if.slave bus
);
    localparam int EW    = WIDTH + 2;     // extended operand width
    localparam int G     = EW / 2;        // number of Booth groups
    localparam int PRODW = 2 * WIDTH;     // exact product width
    localparam int ACC_W = PRODW + GUARD;

    // Partial products are kept modulo 2^PRODW: the true product always fits
    // in PRODW bits, so bits above that can never influence the result.

    logic             stall;

    // Stage 1 (Booth encode) signals
    logic [EW-1:0]    a_ext;
    logic [EW-1:0]    b_ext;
    logic [EW:0]      b_pad;
    logic [PRODW-1:0] a_sx;
    logic [PRODW-1:0] mag;
    logic [2:0]       trip;
    logic             neg;
    logic [PRODW-1:0] pp_d [G];
    logic [PRODW-1:0] pp_q [G];
    logic             v1_q;
    logic             acc1_q;
    logic             sgn1_q;

    // Stage 2 (carry-save reduction) signals
    logic [PRODW-1:0] csa_s;
    logic [PRODW-1:0] csa_c;
    logic [PRODW-1:0] csa_t;
    logic [PRODW-1:0] sum_q;
    logic [PRODW-1:0] carry_q;
    logic             v2_q;
    logic             acc2_q;
    logic             sgn2_q;

    // Stage 3 (final add + accumulate) signals
    logic [PRODW-1:0] prod;
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] acc_q;
    logic             out_valid_q;

    // Only a held result blocks the pipe; in_ready never looks at in_valid.
    assign stall         = out_valid_q & ~bus.out_ready;
    assign bus.in_ready  = ~stall;
    assign bus.out_valid = out_valid_q;
    assign bus.out_p     = acc_q;

    // Extend operands by two bits and build one partial product per Booth digit.
    always_comb begin
        a_ext = {{2{bus.in_a_signed & bus.in_a[WIDTH-1]}}, bus.in_a};
        b_ext = {{2{bus.in_b_signed & bus.in_b[WIDTH-1]}}, bus.in_b};
        b_pad = {b_ext, 1'b0};
        a_sx  = {{(PRODW-EW){a_ext[EW-1]}}, a_ext};
        trip  = 3'b000;
        neg   = 1'b0;
        mag   = '0;
        for (int i = 0; i < G; i++) begin
            trip = b_pad[2*i +: 3];
            neg  = 1'b0;
            case (trip)
                3'b001, 3'b010: mag = a_sx;
                3'b011:         mag = a_sx << 1;
                3'b100: begin
                    mag = a_sx << 1;
                    neg = 1'b1;
                end
                3'b101, 3'b110: begin
                    mag = a_sx;
                    neg = 1'b1;
                end
                default:        mag = '0;
            endcase
            if (neg) begin
                mag = ~mag + PRODW'(1);
            end
            pp_d[i] = mag << (2 * i);
        end
    end

    // Reduce the partial products to a sum/carry pair with a chain of 3:2 compressors.
    always_comb begin
        csa_s = pp_q[0];
        csa_c = pp_q[1];
        csa_t = '0;
        for (int i = 2; i < G; i++) begin
            csa_t = csa_s ^ csa_c ^ pp_q[i];
            csa_c = ((csa_s & csa_c) | (csa_s & pp_q[i]) | (csa_c & pp_q[i])) << 1;
            csa_s = csa_t;
        end
    end

    // Resolve the product, widen it by operand signedness, and load or accumulate.
    always_comb begin
        prod     = sum_q + carry_q;
        prod_ext = {{GUARD{sgn2_q & prod[PRODW-1]}}, prod};
        acc_d    = acc2_q ? (acc_q + prod_ext) : prod_ext;
    end

    // Stage-valid bits and accumulator: advance together unless stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            out_valid_q <= 1'b0;
            acc_q       <= '0;
        end else if (!stall) begin
            v1_q        <= bus.in_valid;
            v2_q        <= v1_q;
            out_valid_q <= v2_q;
            if (v2_q) begin
                acc_q <= acc_d;
            end
        end
    end

    // Datapath pipeline registers: load only when a valid beat moves in.
    always_ff @(posedge clk) begin
        if (!stall) begin
            if (bus.in_valid) begin
                pp_q   <= pp_d;
                acc1_q <= bus.in_acc;
                sgn1_q <= bus.in_a_signed | bus.in_b_signed;
            end
            if (v1_q) begin
                sum_q   <= csa_s;
                carry_q <= csa_c;
                acc2_q  <= acc1_q;
                sgn2_q  <= sgn1_q;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_mult_booth_pipe.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_mult_booth_pipe
// Description : Self-checking bench for mult_booth_pipe (WIDTH=16, ACC_W=40).
//               Reference model multiplies with wide integer arithmetic and
//               keeps a queue of expected results in acceptance order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_booth_pipe;
    localparam int WIDTH = 16;
    localparam int GUARD = 8;
    localparam int ACC_W = 2 * WIDTH + GUARD;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks     = 0;
    int   failures   = 0;
    int   n_accepted = 0;
    logic [ACC_W-1:0] macc = '0;
    logic [ACC_W-1:0] exp_q [$];
    logic [ACC_W-1:0] obs_q [$];

    mult_booth_pipe_if #(.WIDTH(WIDTH), .GUARD(GUARD)) bus ();

    mult_booth_pipe #(.WIDTH(WIDTH), .GUARD(GUARD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Exact product of the two operands interpreted per their flags.
    function automatic logic [ACC_W-1:0] ref_product(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                     input logic a_s, input logic b_s);
        logic signed [127:0] av;
        logic signed [127:0] bv;
        logic signed [127:0] p;
        av = a_s ? 128'($signed(a)) : 128'(a);
        bv = b_s ? 128'($signed(b)) : 128'(b);
        p  = av * bv;
        return p[ACC_W-1:0];
    endfunction

    function automatic logic [ACC_W-1:0] ref_next(input logic [ACC_W-1:0] acc, input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b, input logic a_s,
                                                  input logic b_s, input logic do_acc);
        return do_acc ? acc + ref_product(a, b, a_s, b_s) : ref_product(a, b, a_s, b_s);
    endfunction

    // Reference model and output recorder, both on the active edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            obs_q.delete();
            macc <= '0;
        end else begin
            if (bus.out_valid && bus.out_ready) obs_q.push_back(bus.out_p);
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(ref_next(macc, bus.in_a, bus.in_b, bus.in_a_signed, bus.in_b_signed, bus.in_acc));
                macc       <= ref_next(macc, bus.in_a, bus.in_b, bus.in_a_signed, bus.in_b_signed, bus.in_acc);
                n_accepted <= n_accepted + 1;
            end
        end
    end

    task automatic drive_beat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                              input logic a_s, input logic b_s, input logic do_acc);
        bus.in_valid    = 1'b1;
        bus.in_a        = a;
        bus.in_b        = b;
        bus.in_a_signed = a_s;
        bus.in_b_signed = b_s;
        bus.in_acc      = do_acc;
    endtask

    task automatic drive_idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic flush();
        drive_idle();
        bus.out_ready = 1'b1;
        repeat (6) @(negedge clk);
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
        checks++;
        if (bus.out_p !== '0) begin failures++; $display("FAIL reset_out_p got=%h want=0", bus.out_p); end
        checks++;
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
        rst_n = 1'b1;
    endtask

    // Beat presented before edge 1 must appear after edge 3.
    task automatic test_signed_corner();
        flush();
        drive_beat(16'h8000, 16'h8000, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        drive_idle();
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL corner_early1 got=%b want=0", bus.out_valid); end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL corner_early2 got=%b want=0", bus.out_valid); end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL corner_latency got=%b want=1", bus.out_valid); end
        checks++;
        if (bus.out_p !== 40'h0040000000) begin failures++; $display("FAIL corner_value got=%h want=0040000000", bus.out_p); end
    endtask

    task automatic test_unsigned_mixed();
        flush();
        drive_beat(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive_beat(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        drive_idle();
        repeat (5) @(negedge clk);
        checks++;
        if (obs_q.size() != 2) begin
            failures++; $display("FAIL unsmix_count got=%0d want=2", obs_q.size());
        end else begin
            checks++;
            if (obs_q[0] !== 40'h00FFFE0001) begin failures++; $display("FAIL unsigned_corner got=%h want=00FFFE0001", obs_q[0]); end
            checks++;
            if (obs_q[1] !== 40'hFFFFFF0001) begin failures++; $display("FAIL mixed_sign got=%h want=FFFFFF0001", obs_q[1]); end
        end
    endtask

    task automatic test_accum_chain();
        logic [WIDTH-1:0] ca [4] = '{16'd3, 16'hFFFE, 16'd7, 16'd1};
        logic [WIDTH-1:0] cb [4] = '{16'd4, 16'd5, 16'd7, 16'd1};
        logic             cacc [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [ACC_W-1:0] want [4] = '{40'd12, 40'd2, 40'd51, 40'd1};
        logic             ov [8];
        logic [ACC_W-1:0] op [8];
        flush();
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            ov[c] = bus.out_valid;
            op[c] = bus.out_p;
            if (c < 4) drive_beat(ca[c], cb[c], 1'b1, 1'b1, cacc[c]);
            else drive_idle();
        end
        checks++;
        if (ov[2] !== 1'b0) begin failures++; $display("FAIL chain_pre got=%b want=0", ov[2]); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (ov[3+k] !== 1'b1 || op[3+k] !== want[k])
                begin failures++; $display("FAIL chain_%0d valid=%b got=%0d want=%0d", k, ov[3+k], op[3+k], want[k]); end
        end
        checks++;
        if (ov[7] !== 1'b0) begin failures++; $display("FAIL chain_post got=%b want=0", ov[7]); end
    endtask

    task automatic test_backpressure();
        int               base;
        int               last_acc;
        int               stall_seen = 0;
        logic             held = 1'b0;
        logic [ACC_W-1:0] hold_p = '0;
        flush();
        base     = n_accepted;
        last_acc = n_accepted;
        for (int c = 0; c < 30; c++) begin
            if (c > 0) @(negedge clk);
            if (held) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_p !== hold_p)
                    begin failures++; $display("FAIL bp_hold valid=%b got=%h want=%h", bus.out_valid, bus.out_p, hold_p); end
                checks++;
                if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b want=0", bus.in_ready); end
            end
            bus.out_ready = !(c >= 3 && c <= 7);
            held   = bus.out_valid && !bus.out_ready;
            hold_p = bus.out_p;
            if (held) stall_seen++;
            if (n_accepted - base < 6) begin
                if (!bus.in_valid || n_accepted != last_acc) begin
                    drive_beat(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
                    last_acc = n_accepted;
                end
            end else begin
                drive_idle();
            end
        end
        checks++;
        if (stall_seen != 5) begin failures++; $display("FAIL bp_stall_cycles got=%0d want=5", stall_seen); end
        checks++;
        if (obs_q.size() != 6 || exp_q.size() != 6) begin
            failures++; $display("FAIL bp_count got=%0d want=6 (model %0d)", obs_q.size(), exp_q.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (obs_q[k] !== exp_q[k]) begin failures++; $display("FAIL bp_result_%0d got=%h want=%h", k, obs_q[k], exp_q[k]); end
            end
        end
    endtask

    task automatic test_reset_midflight();
        flush();
        drive_beat(16'd5, 16'd5, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive_beat(16'd6, 16'd6, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        drive_idle();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b want=0", bus.out_valid); end
        checks++;
        if (bus.out_p !== '0) begin failures++; $display("FAIL midrst_acc got=%h want=0", bus.out_p); end
        repeat (4) @(negedge clk);
        checks++;
        if (obs_q.size() != 0) begin failures++; $display("FAIL midrst_dropped got=%0d outputs want=0", obs_q.size()); end
        drive_beat(16'd2, 16'd3, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        drive_idle();
        repeat (4) @(negedge clk);
        checks++;
        if (obs_q.size() != 1 || obs_q[0] !== 40'd6)
            begin failures++; $display("FAIL midrst_after count=%0d got=%h want=6", obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : '0); end
    endtask

    task automatic test_random();
        int               base;
        int               target = 3000;
        logic [ACC_W-1:0] o;
        logic [ACC_W-1:0] e;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        flush();
        base = n_accepted;
        for (int c = 0; c < 30000; c++) begin
            @(negedge clk);
            while (obs_q.size() > 0) begin
                o = obs_q.pop_front();
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL rand_spurious got=%h want=none", o);
                end else begin
                    e = exp_q.pop_front();
                    if (o !== e) begin failures++; $display("FAIL rand_result got=%h want=%h", o, e); end
                end
            end
            if (n_accepted - base >= target && exp_q.size() == 0) break;
            bus.out_ready = ($urandom_range(9) < 7);
            if (n_accepted - base < target && $urandom_range(3) != 0) begin
                ra = ($urandom_range(7) == 0) ? {1'b1, {(WIDTH-1){1'b0}}} : WIDTH'($urandom);
                rb = ($urandom_range(7) == 0) ? {WIDTH{1'b1}} : WIDTH'($urandom);
                drive_beat(ra, rb, 1'($urandom), 1'($urandom), 1'($urandom));
            end else begin
                drive_idle();
            end
        end
        checks++;
        if (n_accepted - base < target || exp_q.size() != 0)
            begin failures++; $display("FAIL rand_timeout accepted=%0d pending=%0d want=%0d/0", n_accepted - base, exp_q.size(), target); end
    endtask

    // Repeated max unsigned products overflow the 40-bit accumulator.
    task automatic test_wrap();
        logic [ACC_W-1:0] step;
        logic [ACC_W-1:0] e = '0;
        step = ACC_W'({WIDTH{1'b1}}) * ACC_W'({WIDTH{1'b1}});
        flush();
        for (int k = 0; k < 300; k++) begin
            drive_beat({WIDTH{1'b1}}, {WIDTH{1'b1}}, 1'b0, 1'b0, (k != 0));
            @(negedge clk);
        end
        drive_idle();
        repeat (5) @(negedge clk);
        checks++;
        if (obs_q.size() != 300) begin
            failures++; $display("FAIL wrap_count got=%0d want=300", obs_q.size());
        end else begin
            for (int k = 0; k < 300; k++) begin
                e = e + step;
                checks++;
                if (obs_q[k] !== e) begin failures++; $display("FAIL wrap_%0d got=%h want=%h", k, obs_q[k], e); end
            end
        end
    endtask

    initial begin
        bus.in_valid    = 1'b0;
        bus.in_a        = '0;
        bus.in_b        = '0;
        bus.in_a_signed = 1'b0;
        bus.in_b_signed = 1'b0;
        bus.in_acc      = 1'b0;
        bus.out_ready   = 1'b1;
        test_reset();
        test_signed_corner();
        test_unsigned_mixed();
        test_accum_chain();
        test_backpressure();
        test_reset_midflight();
        test_random();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
